// File: rtl/rpc_cmd_scheduler.sv
// Single-port RPC DRAM command sequencer: one data transaction in flight, periodic refresh first.
// Optional data-completion watchdog enabled by RPC_CMD_SCHED_TIMEOUT_EN.
module rpc_cmd_scheduler #(
  parameter int DramLenWidth  = 6,
  parameter int DramAddrWidth = 20,
  parameter int RefreshCycles = 3900,
  parameter int TrfcCycles    = 64,
  parameter int MaxPending    = 7,
  parameter int TimeoutCycles = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_is_write_i,
  input  logic [DramLenWidth-1:0]  req_len_i,
  input  logic [DramAddrWidth-1:0] req_addr_i,
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output logic                     cmd_is_write_o,
  output logic                     cmd_is_ref_o,
  output logic [DramLenWidth-1:0]  cmd_len_o,
  output logic [DramAddrWidth-1:0] cmd_addr_o,
  input  logic                     w_beat_i,
  input  logic                     r_last_i,
  output logic                     busy_o,
  output logic [3:0]               ref_pending_o,
  output logic                     timeout_o
);

  // Handshakes: a transfer happens on a rising clk_i edge where valid and ready are both 1;
  // cmd_valid_o and its fields stay stable until cmd_ready_i, req_ready_o never waits on itself.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_W    = 3'd2;
  localparam logic [2:0] ST_WAIT_R    = 3'd3;
  localparam logic [2:0] ST_REF_ISSUE = 3'd4;
  localparam logic [2:0] ST_REF_WAIT  = 3'd5;

  localparam int TimerW = $clog2(RefreshCycles);
  localparam int TrfcW  = $clog2(TrfcCycles + 1);

  logic [2:0]               state_q, state_d;
  logic [TimerW-1:0]        timer_q;
  logic [3:0]               pend_q;
  logic                     lat_is_write_q;
  logic [DramLenWidth-1:0]  lat_len_q;
  logic [DramAddrWidth-1:0] lat_addr_q;
  logic [DramLenWidth:0]    beat_q;
  logic [DramLenWidth:0]    len_p1;
  logic [TrfcW-1:0]         trfc_q;
  logic                     busy_q;
  logic                     due;
  logic                     ref_hs;
  logic                     cmd_hs;

  assign due    = (timer_q == TimerW'(RefreshCycles - 1));
  assign ref_hs = (state_q == ST_REF_ISSUE) && cmd_ready_i;
  assign cmd_hs = (state_q == ST_ISSUE) && cmd_ready_i;
  assign len_p1 = {1'b0, lat_len_q} + (DramLenWidth + 1)'(1);

  assign req_ready_o    = rst_ni && (state_q == ST_IDLE) && (pend_q == 4'd0) && req_valid_i;
  assign cmd_valid_o    = (state_q == ST_ISSUE) || (state_q == ST_REF_ISSUE);
  assign cmd_is_ref_o   = (state_q == ST_REF_ISSUE);
  assign cmd_is_write_o = (state_q == ST_ISSUE) && lat_is_write_q;
  assign cmd_len_o      = (state_q == ST_ISSUE) ? lat_len_q : '0;
  assign cmd_addr_o     = (state_q == ST_ISSUE) ? lat_addr_q : '0;
  assign busy_o         = busy_q;
  assign ref_pending_o  = pend_q;

`ifdef RPC_CMD_SCHED_TIMEOUT_EN
  localparam int WdW = $clog2(TimeoutCycles + 1);
  logic [WdW-1:0] wd_q;
  logic           timeout_q;
  logic           timeout_d;
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
`ifdef RPC_CMD_SCHED_TIMEOUT_EN
    timeout_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pend_q != 4'd0)   state_d = ST_REF_ISSUE;
        else if (req_valid_i) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (cmd_ready_i) begin
          // A single-word write whose only beat lands on the handshake is already done.
          if (lat_is_write_q)
            state_d = (w_beat_i && (lat_len_q == '0)) ? ST_IDLE : ST_WAIT_W;
          else
            state_d = ST_WAIT_R;
        end
      end
      ST_WAIT_W: begin
        if (w_beat_i && ((beat_q + (DramLenWidth + 1)'(1)) == len_p1)) state_d = ST_IDLE;
      end
      ST_WAIT_R: begin
        if (r_last_i) state_d = ST_IDLE;
      end
      ST_REF_ISSUE: begin
        if (cmd_ready_i) state_d = ST_REF_WAIT;
      end
      ST_REF_WAIT: begin
        if (trfc_q == TrfcW'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef RPC_CMD_SCHED_TIMEOUT_EN
    if (((state_q == ST_WAIT_W) || (state_q == ST_WAIT_R)) && (state_d == state_q) &&
        !w_beat_i && (wd_q == WdW'(TimeoutCycles - 1))) begin
      state_d   = ST_IDLE;
      timeout_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      busy_q         <= 1'b0;
      timer_q        <= '0;
      pend_q         <= 4'd0;
      lat_is_write_q <= 1'b0;
      lat_len_q      <= '0;
      lat_addr_q     <= '0;
      beat_q         <= '0;
      trfc_q         <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      timer_q <= due ? '0 : timer_q + TimerW'(1);

      // A due event and a refresh handshake in the same cycle cancel out.
      if (due && !ref_hs && (pend_q < 4'(MaxPending))) pend_q <= pend_q + 4'd1;
      else if (!due && ref_hs)                         pend_q <= pend_q - 4'd1;

      if (req_ready_o) begin
        lat_is_write_q <= req_is_write_i;
        lat_len_q      <= req_len_i;
        lat_addr_q     <= req_addr_i;
      end

      if (cmd_hs)                                  beat_q <= (DramLenWidth + 1)'(w_beat_i);
      else if ((state_q == ST_WAIT_W) && w_beat_i) beat_q <= beat_q + (DramLenWidth + 1)'(1);

      if (ref_hs)                          trfc_q <= TrfcW'(TrfcCycles);
      else if (state_q == ST_REF_WAIT)     trfc_q <= trfc_q - TrfcW'(1);
    end
  end

`ifdef RPC_CMD_SCHED_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
      if (cmd_hs || w_beat_i)                                 wd_q <= '0;
      else if ((state_q == ST_WAIT_W) || (state_q == ST_WAIT_R)) wd_q <= wd_q + WdW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_rpc_cmd_scheduler.sv
// Bench for rpc_cmd_scheduler: directed vectors, corner sequences and random traffic
// checked every cycle against a job-level reference model.
module tb_rpc_cmd_scheduler;

  localparam int LW  = 6;
  localparam int AW  = 20;
  localparam int R   = 16;
  localparam int T   = 5;
  localparam int MP  = 7;
  localparam int TO  = 8;
  localparam int EW  = 1 + LW + AW;

  localparam int JOB_NONE = 0;
  localparam int JOB_DATA = 1;
  localparam int JOB_REF  = 2;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          req_valid, req_is_write, cmd_ready, w_beat, r_last;
  logic [LW-1:0] req_len;
  logic [AW-1:0] req_addr;
  logic          req_ready_o, cmd_valid_o, cmd_is_write_o, cmd_is_ref_o, busy_o, timeout_o;
  logic [LW-1:0] cmd_len_o;
  logic [AW-1:0] cmd_addr_o;
  logic [3:0]    ref_pending_o;

  rpc_cmd_scheduler #(
    .DramLenWidth(LW), .DramAddrWidth(AW), .RefreshCycles(R),
    .TrfcCycles(T), .MaxPending(MP), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_is_write_i(req_is_write),
    .req_len_i(req_len), .req_addr_i(req_addr),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready), .cmd_is_write_o(cmd_is_write_o),
    .cmd_is_ref_o(cmd_is_ref_o), .cmd_len_o(cmd_len_o), .cmd_addr_o(cmd_addr_o),
    .w_beat_i(w_beat), .r_last_i(r_last),
    .busy_o(busy_o), .ref_pending_o(ref_pending_o), .timeout_o(timeout_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- scoreboard / counters ----------------
  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int ready_seen = 0;
  bit last_ready = 0;
  logic [EW-1:0] exp_q[$];

  typedef struct { bit is_ref; int cyc; } hs_t;
  hs_t hs_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model (job level) ----------------
  int m_timer, m_pend, m_job, m_remain, m_len, m_addr, m_idle_run, m_dues;
  bit m_issued, m_wr, m_timeout;

  task automatic model_reset();
    m_timer = 0; m_pend = 0; m_job = JOB_NONE; m_issued = 0; m_remain = 0;
    m_idle_run = 0; m_timeout = 0; m_wr = 0; m_len = 0; m_addr = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit due, ref_hs, done;
    int pend_before;
    if (!rst_ni) begin
      model_reset();
      return;
    end
    due = (m_timer == R - 1);
    m_timer = due ? 0 : m_timer + 1;
    if (due) m_dues++;
    ref_hs = (m_job == JOB_REF) && !m_issued && cmd_ready;
    pend_before = m_pend;
    if (due && !ref_hs) m_pend = (m_pend < MP) ? m_pend + 1 : m_pend;
    else if (!due && ref_hs) m_pend = m_pend - 1;
    m_timeout = 0;
    case (m_job)
      JOB_NONE: begin
        if (pend_before > 0) begin
          m_job = JOB_REF; m_issued = 0;
        end else if (req_valid) begin
          m_job = JOB_DATA; m_issued = 0;
          m_wr = req_is_write; m_len = int'(req_len); m_addr = int'(req_addr);
          exp_q.push_back({req_is_write, req_len, req_addr});
        end
      end
      JOB_REF: begin
        if (!m_issued) begin
          if (cmd_ready) begin m_issued = 1; m_remain = T; end
        end else begin
          m_remain--;
          if (m_remain == 0) m_job = JOB_NONE;
        end
      end
      default: begin
        if (!m_issued) begin
          if (cmd_ready) begin
            m_issued = 1; m_idle_run = 0;
            if (m_wr) begin
              m_remain = m_len + 1 - int'(w_beat);
              if (m_remain == 0) m_job = JOB_NONE;
            end
          end
        end else begin
          done = m_wr ? (w_beat && m_remain == 1) : r_last;
          if (m_wr && w_beat) m_remain--;
          if (done) m_job = JOB_NONE;
`ifdef RPC_CMD_SCHED_TIMEOUT_EN
          else begin
            m_idle_run = w_beat ? 0 : m_idle_run + 1;
            if (m_idle_run == TO) begin m_job = JOB_NONE; m_timeout = 1; end
          end
`endif
        end
      end
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic quiet();
    req_valid = 0; req_is_write = 0; req_len = '0; req_addr = '0;
    cmd_ready = 0; w_beat = 0; r_last = 0;
  endtask

  // One clock: check combinational outputs before the edge, step model, check registered after.
  task automatic cycle();
    bit exp_ready, exp_valid;
    logic [EW-1:0] e;
    #2;
    exp_ready = rst_ni && (m_job == JOB_NONE) && (m_pend == 0) && req_valid;
    exp_valid = (m_job != JOB_NONE) && !m_issued;
    check("req_ready", req_ready_o, exp_ready);
    check("cmd_valid", cmd_valid_o, exp_valid);
    if (exp_valid) check("cmd_is_ref", cmd_is_ref_o, m_job == JOB_REF);
    last_ready = req_ready_o;
    ready_seen += int'(req_ready_o);
    if (cmd_valid_o && cmd_ready) begin
      hs_q.push_back('{cmd_is_ref_o, cyc});
      if (cmd_is_ref_o) check("ref_fields_zero", {cmd_is_write_o, cmd_len_o, cmd_addr_o}, 0);
      else if (exp_q.size() == 0) check("cmd_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("cmd_fields", {cmd_is_write_o, cmd_len_o, cmd_addr_o}, e);
      end
    end
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    check("busy", busy_o, m_job != JOB_NONE);
    check("ref_pending", ref_pending_o, m_pend);
    check("timeout", timeout_o, m_timeout);
  endtask

  task automatic sync_idle(input int want_timer);
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (m_job == JOB_NONE && m_pend == 0 && (want_timer < 0 || m_timer == want_timer)) ok = 1;
      else begin
        quiet(); cmd_ready = 1; w_beat = 1; r_last = 1;
        cycle();
      end
    end
    check("sync_bound", ok, 1);
    quiet();
  endtask

  typedef struct {
    bit is_write; int len; int addr; int rdy_delay; int rlat; int exp_busy;
  } vec_t;

  task automatic run_vec(input vec_t v, input string name);
    int busy_cnt = 0;
    sync_idle(-1);
    req_valid = 1; req_is_write = v.is_write; req_len = LW'(v.len); req_addr = AW'(v.addr);
    cycle(); busy_cnt += int'(busy_o);
    check({name, "_accept"}, last_ready, 1);
    req_is_write = ~v.is_write; req_len = ~LW'(v.len); req_addr = ~AW'(v.addr);
    for (int i = 0; i < v.rdy_delay; i++) begin cycle(); busy_cnt += int'(busy_o); end
    cmd_ready = 1;
    cycle(); busy_cnt += int'(busy_o);
    cmd_ready = 0;
    if (v.is_write) begin
      w_beat = 1;
      for (int i = 0; i <= v.len; i++) begin cycle(); busy_cnt += int'(busy_o); end
    end else begin
      for (int i = 0; i < v.rlat - 1; i++) begin cycle(); busy_cnt += int'(busy_o); end
      r_last = 1;
      cycle(); busy_cnt += int'(busy_o);
    end
    quiet();
    check({name, "_busy_cycles"}, busy_cnt, v.exp_busy);
    check({name, "_done_idle"}, busy_o, 0);
  endtask

  // ---------------- test ----------------
  vec_t vecs[5];

  initial begin
    int first_valid, last_busy, d0, to_n;
    vecs[0] = '{1'b1, 3,  'h12345, 2, 0, 7};
    vecs[1] = '{1'b0, 0,  'h00001, 0, 3, 4};
    vecs[2] = '{1'b1, 0,  'hFFFFF, 1, 0, 3};
    vecs[3] = '{1'b0, 63, 'h80000, 3, 1, 5};
    vecs[4] = '{1'b1, 5,  'h00000, 0, 0, 7};

    rst_ni = 0; quiet();
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check("reset_outputs", {req_ready_o, cmd_valid_o, cmd_is_write_o, cmd_is_ref_o, cmd_len_o,
                            cmd_addr_o, busy_o, ref_pending_o, timeout_o}, 0);
    rst_ni = 1;

    // First refresh after reset release, then TrfcCycles of recovery with requests held off.
    first_valid = 0; last_busy = 0; ready_seen = 0;
    for (int n = 1; n <= 24; n++) begin
      quiet(); cmd_ready = 1; req_valid = (n >= 18 && n <= 23);
      cycle();
      if (cmd_valid_o && first_valid == 0) first_valid = n;
      if (busy_o) last_busy = n;
    end
    check("first_ref_cycle", first_valid, 17);
    check("ref_busy_last", last_busy, 22);
    check("ready_during_ref", ready_seen, 0);
    quiet();

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Refresh becomes due while a read waits: refresh goes out first.
    sync_idle(R - 1);
    cycle();
    hs_q.delete();
    req_valid = 1; req_is_write = 0; req_len = '0; req_addr = 'h0ABCD; cmd_ready = 1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (last_ready) begin req_valid = 0; r_last = 1; end
      if (hs_q.size() >= 2 && m_job == JOB_NONE) break;
    end
    quiet();
    check("order_count", hs_q.size(), 2);
    if (hs_q.size() >= 2) begin
      check("order_first_ref", hs_q[0].is_ref, 1);
      check("order_second_read", hs_q[1].is_ref, 0);
    end

    // Pending counter saturation and back-to-back drain.
    sync_idle(-1);
    for (int i = 0; i < 40 * R; i++) cycle();
    check("pend_saturated", ref_pending_o, MP);
    check("ref_stuck_valid", {cmd_valid_o, cmd_is_ref_o}, 3);
    hs_q.delete(); d0 = m_dues; cmd_ready = 1;
    for (int i = 0; i < 300 && !(m_pend == 0 && m_job == JOB_NONE); i++) cycle();
    quiet();
    check("drain_ref_count", hs_q.size(), MP + (m_dues - d0));
    for (int i = 1; i < MP && i < hs_q.size(); i++)
      check($sformatf("drain_gap%0d", i), hs_q[i].cyc - hs_q[i-1].cyc, T + 2);

    // Reset in the middle of a write burst.
    sync_idle(-1);
    req_valid = 1; req_is_write = 1; req_len = 6'd3; req_addr = 'h5A5A5;
    cycle();
    quiet(); cmd_ready = 1;
    cycle();
    quiet(); w_beat = 1;
    cycle(); cycle();
    quiet(); rst_ni = 0;
    cycle();
    check("rst_mid_outputs", {req_ready_o, cmd_valid_o, cmd_is_write_o, cmd_is_ref_o, cmd_len_o,
                              cmd_addr_o, busy_o, ref_pending_o, timeout_o}, 0);
    rst_ni = 1;
    run_vec(vecs[0], "post_rst");

    // Read whose last word never arrives.
    sync_idle(-1);
    req_valid = 1; req_is_write = 0; req_len = 6'd2; req_addr = 'h00077;
    cycle();
    quiet(); cmd_ready = 1;
    cycle();
    quiet();
    to_n = 0;
    for (int n = 1; n <= 20; n++) begin
      cycle();
      if (timeout_o && to_n == 0) to_n = n;
    end
`ifdef RPC_CMD_SCHED_TIMEOUT_EN
    check("timeout_cycle", to_n, TO);
    check("timeout_idle", busy_o, 0);
`else
    check("no_timeout", to_n, 0);
    check("read_still_busy", busy_o, 1);
    r_last = 1;
    cycle();
    quiet();
    check("read_released", busy_o, 0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      req_valid    = ($urandom_range(0, 2) == 0);
      req_is_write = $urandom_range(0, 1);
      req_len      = LW'($urandom_range(0, 7));
      req_addr     = AW'($urandom);
      cmd_ready    = ($urandom_range(0, 3) != 0);
      w_beat       = $urandom_range(0, 1);
      r_last       = ($urandom_range(0, 4) == 0);
      cycle();
    end
    sync_idle(-1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rpc_cmd_scheduler.md
Name: rpc_cmd_scheduler

Overview:
Sequences the single RPC DRAM command port between AXI-derived read/write commands and internally generated periodic refresh. Sits between the AXI-to-RPC interface command output and the DRAM controller/PHY command input. Admits at most one data transaction in flight: the next command is issued only after the previous burst's data has completed on the PHY side. Refresh has priority at every idle point.

Parameters:
DramLenWidth, 6, width of burst length field; burst carries len+1 words
DramAddrWidth, 20, width of command address
RefreshCycles, 3900, clk cycles between refresh-due events (>=2)
TrfcCycles, 64, idle cycles enforced after a refresh command is accepted (>=1)
MaxPending, 7, saturation limit of pending-refresh counter (1..15)
TimeoutCycles, 1024, data-completion watchdog limit (optional feature only)

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
req_valid_i  in  1  upstream command valid
req_ready_o  out  1  upstream command accepted
req_is_write_i  in  1  1=write, 0=read
req_len_i  in  DramLenWidth  burst length minus one
req_addr_i  in  DramAddrWidth  command address
cmd_valid_o  out  1  command to controller valid
cmd_ready_i  in  1  controller accepts command
cmd_is_write_o  out  1  write command
cmd_is_ref_o  out  1  refresh command (len/addr zero)
cmd_len_o  out  DramLenWidth  burst length minus one
cmd_addr_o  out  DramAddrWidth  address
w_beat_i  in  1  one write word transferred to PHY (valid&ready)
r_last_i  in  1  final read word transferred from PHY (valid&ready&last)
busy_o  out  1  FSM not in IDLE
ref_pending_o  out  4  pending refresh count
timeout_o  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset (rst_ni=0 at posedge): FSM=IDLE; all outputs 0; refresh timer=0; pending=0; beat counter=0. Reset mid-burst abandons the transaction with no further outputs.
- Refresh timer: increments every cycle; at RefreshCycles-1 wraps to 0 and raises a due event. Pending += 1 on due, -= 1 on refresh command handshake; both same cycle -> unchanged; saturates at MaxPending (extra due events dropped).
- States:
  IDLE: if pending>0 -> REF_ISSUE (refresh wins even if req_valid_i=1). Else if req_valid_i -> req_ready_o=1 for that cycle, latch is_write/len/addr -> ISSUE. req_ready_o is combinational, only in IDLE with pending==0.
  ISSUE: cmd_valid_o=1 with latched fields, held stable until cmd_ready_i. On handshake -> WAIT_W (write) or WAIT_R (read); beat counter cleared.
  WAIT_W: count w_beat_i; at the beat that makes count == len+1 -> IDLE. Beats that arrive in the ISSUE handshake cycle are counted.
  WAIT_R: on r_last_i -> IDLE.
  REF_ISSUE: cmd_valid_o=1, cmd_is_ref_o=1, is_write/len/addr=0; on cmd_ready_i -> REF_WAIT, load counter with TrfcCycles.
  REF_WAIT: decrement; at 0 -> IDLE.
- Minimum 1 idle cycle in IDLE between any two commands; cmd_valid_o never asserted in IDLE, WAIT_*, REF_WAIT.
- Refresh due arriving during ISSUE/WAIT_* is only counted; no preemption.
- w_beat_i/r_last_i outside their WAIT state are ignored.
- busy_o = (state != IDLE), registered.

Optional Feature:
Macro RPC_CMD_SCHED_TIMEOUT_EN. Enabled: watchdog counter cleared on entry to WAIT_W/WAIT_R, increments each cycle there, reset on every w_beat_i; reaching TimeoutCycles forces IDLE and pulses timeout_o for 1 cycle. Disabled: no watchdog logic; timeout_o tied 0; WAIT states wait indefinitely.

Test Plan:
Reset then RefreshCycles=16: first refresh cmd_valid_o at cycle 17 after reset release; ready immediate -> busy for TrfcCycles, req_ready_o low throughout.
Write len=3, cmd_ready_i after 2 cycles, 4 w_beat_i pulses -> return to IDLE on 4th beat, next request accepted no earlier than 1 cycle later.
Read len=0 with req_valid_i held and refresh due same cycle in IDLE -> refresh issued first, read issued after REF_WAIT.
Hold cmd_ready_i=0 across 40 refresh periods with MaxPending=7 -> ref_pending_o saturates at 7; after drain, 7 refresh commands issued back-to-back (each separated by REF_WAIT).
Assert rst_ni=0 during WAIT_W after 2 of 4 beats -> all outputs 0 next cycle, pending 0, new write behaves normally.
With RPC_CMD_SCHED_TIMEOUT_EN, TimeoutCycles=8, read with no r_last_i -> timeout_o pulses 8 cycles after WAIT_R entry, FSM IDLE; without macro -> timeout_o stays 0, busy_o stays 1.
